bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer_pkg.sv | 20 ++
 rtl/bit_serializer_hold.sv | 33 +++
 rtl/bit_serializer.sv | 119 +++++++++++
 tb/tb_bit_serializer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the bit serializer.
// Optional trailing even-parity bit is enabled by defining BIT_SERIALIZER_PARITY_EN.
package bit_serializer_pkg;

    localparam int WIDTH_DEFAULT = 8;

`ifdef BIT_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

endpackage

// File: rtl/bit_serializer_hold.sv
// Single-entry holding register for the word queued behind the one being shifted.
// Owns the full flag and the load_ready handshake seen by the producer.
module bit_serializer_hold
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] hold_data,
    output logic             hold_full,
    output logic             load_ready
);

    // push and pop never coincide: push needs an empty hold, pop needs a full one
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data <= '0;
            hold_full <= 1'b0;
        end else if (push) begin
            hold_data <= data_in;
            hold_full <= 1'b1;
        end else if (pop) begin
            hold_full <= 1'b0;
        end
    end

    assign load_ready = !hold_full && !rst;

endmodule

// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial converter with a one-word holding register.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit to every word.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, next_state;
    logic [CW-1:0]    count, next_count;
    logic [WIDTH-1:0] shift_reg, next_shift, rotated, hold_data;
    logic             hold_full, hold_push, hold_pop;
    logic             accept, last_bit, frame_end;

    bit_serializer_hold #(.WIDTH(WIDTH)) u_hold (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .push      (hold_push),
        .pop       (hold_pop),
        .hold_data (hold_data),
        .hold_full (hold_full),
        .load_ready(load_ready)
    );

    assign accept   = load_valid && load_ready;
    assign last_bit = (state == SHIFT) && (count == LAST);
    // Rotating keeps the whole word intact, so its XOR is still available for parity
    assign rotated  = {shift_reg[WIDTH-2:0], shift_reg[WIDTH-1]};

`ifdef BIT_SERIALIZER_PARITY_EN
    assign frame_end = (state == PARITY);
`else
    assign frame_end = last_bit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            shift_reg <= '0;
        end else begin
            state     <= next_state;
            count     <= next_count;
            shift_reg <= next_shift;
        end
    end

    // At a frame boundary the held word wins; otherwise a fresh word bypasses hold
    always_comb begin
        next_state = state;
        next_count = count;
        next_shift = shift_reg;
        hold_push  = 1'b0;
        hold_pop   = 1'b0;
        if (frame_end) begin
            next_count = '0;
            if (hold_full) begin
                next_state = SHIFT;
                next_shift = hold_data;
                hold_pop   = 1'b1;
            end else if (accept) begin
                next_state = SHIFT;
                next_shift = data_in;
            end else begin
                next_state = IDLE;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        next_state = SHIFT;
                        next_shift = data_in;
                        next_count = '0;
                    end
                end
                SHIFT: begin
                    next_shift = rotated;
                    next_count = count + 1'b1;
                    hold_push  = accept;
`ifdef BIT_SERIALIZER_PARITY_EN
                    if (last_bit) begin
                        next_state = PARITY;
                    end
`endif
                end
                default: next_state = IDLE;
            endcase
        end
    end

    assign ser_valid = !rst && (state != IDLE);
    assign word_done = !rst && frame_end;

    always_comb begin
        ser_out = 1'b0;
        if (ser_valid) begin
            ser_out = shift_reg[WIDTH-1];
`ifdef BIT_SERIALIZER_PARITY_EN
            if (state == PARITY) begin
                ser_out = ^shift_reg;
            end
`endif
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: vector table, directed sequences and a
// randomized run against a frame-level reference model (honours BIT_SERIALIZER_PARITY_EN).
module tb_bit_serializer;

    localparam int W = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    typedef struct {
        logic         rst;
        logic         lv;
        logic [W-1:0] data;
        logic         ready;
        logic         valid;
        logic         out;
        logic         done;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic         load_ready;
    logic         ser_out;
    logic         ser_valid;
    logic         word_done;
    logic [W-1:0] data_in;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    // Reference model: bits left in the current frame, current word, queued word
    int           m_rem  = 0;
    logic [W-1:0] m_cur  = '0;
    logic [W-1:0] m_hold = '0;
    logic         m_held = 1'b0;

    logic cap_bits[$];
    int   cap_first;
    int   cap_last;
    vec_t vecs[$];

    bit_serializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .word_done (word_done)
    );

    always #5 clk = ~clk;

    function automatic logic bitOf(input logic [W-1:0] w, input int k);
        if (k < W) return w[W-1-k];
        return ^w;
    endfunction

    function automatic vec_t mkVec(input logic r, input logic lv, input logic [W-1:0] d,
                                   input logic er, input logic ev, input logic eo, input logic ed);
        vec_t v;
        v.rst = r; v.lv = lv; v.data = d;
        v.ready = er; v.valid = ev; v.out = eo; v.done = ed;
        return v;
    endfunction

    task automatic checkOne(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input logic er, input logic ev,
                               input logic eo, input logic ed);
        checkOne({tag, ".load_ready"}, load_ready, er);
        checkOne({tag, ".ser_valid"}, ser_valid, ev);
        checkOne({tag, ".ser_out"}, ser_out, eo);
        checkOne({tag, ".word_done"}, word_done, ed);
    endtask

    task automatic applyStimulus(input logic r, input logic lv, input logic [W-1:0] d);
        rst        = r;
        load_valid = lv;
        data_in    = d;
    endtask

    task automatic capture();
        if (ser_valid) begin
            cap_bits.push_back(ser_out);
            if (cap_bits.size() == 1) cap_first = cycle;
            cap_last = cycle;
        end
    endtask

    task automatic modelStep(input logic r, input logic lv, input logic [W-1:0] d);
        logic acc;
        if (r) begin
            m_rem  = 0;
            m_held = 1'b0;
        end else begin
            acc = lv && !m_held;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    if (m_held) begin
                        m_cur  = m_hold;
                        m_rem  = FRAME;
                        m_held = 1'b0;
                    end else if (acc) begin
                        m_cur = d;
                        m_rem = FRAME;
                    end
                end else if (acc) begin
                    m_hold = d;
                    m_held = 1'b1;
                end
            end else if (acc) begin
                m_cur = d;
                m_rem = FRAME;
            end
        end
    endtask

    // Inputs change at negedge, outputs are sampled 1 time unit later
    task automatic runModelCycle(input string tag, input logic r, input logic lv,
                                 input logic [W-1:0] d, output logic accepted);
        logic er, ev, eo, ed;
        applyStimulus(r, lv, d);
        #1;
        er = !r && !m_held;
        ev = !r && (m_rem > 0);
        eo = ev ? bitOf(m_cur, FRAME - m_rem) : 1'b0;
        ed = ev && (m_rem == 1);
        checkOutput(tag, er, ev, eo, ed);
        accepted = lv && er;
        capture();
        modelStep(r, lv, d);
        @(negedge clk);
        cycle++;
    endtask

    task automatic runVector(input string tag, input vec_t v);
        applyStimulus(v.rst, v.lv, v.data);
        #1;
        checkOutput(tag, v.ready, v.valid, v.out, v.done);
        capture();
        modelStep(v.rst, v.lv, v.data);
        @(negedge clk);
        cycle++;
    endtask

    task automatic idleCycles(input string tag, input int n);
        logic acc;
        for (int i = 0; i < n; i++) runModelCycle(tag, 1'b0, 1'b0, '0, acc);
    endtask

    task automatic checkStream(input string tag, input logic [W-1:0] words[$]);
        int bad = 0;
        int n;
        n = words.size() * FRAME;
        checkInt({tag, ".bit_count"}, cap_bits.size(), n);
        for (int i = 0; i < n && i < cap_bits.size(); i++) begin
            if (cap_bits[i] !== bitOf(words[i / FRAME], i % FRAME)) bad++;
        end
        checkInt({tag, ".bit_errors"}, bad, 0);
    endtask

    initial begin
        logic         acc;
        logic [W-1:0] words[$];
        logic [W-1:0] tbl_word;
        logic [FRAME-1:0] tbl_bits;
        int           idx;
        int           mask;

        applyStimulus(1'b1, 1'b0, '0);
        @(negedge clk);

        // Single word from idle, written out as literal expected values
`ifdef BIT_SERIALIZER_PARITY_EN
        tbl_word = 8'h07;
        tbl_bits = 9'b0_0000_1111;
`else
        tbl_word = 8'hA5;
        tbl_bits = 8'b1010_0101;
`endif
        vecs.push_back(mkVec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mkVec(1'b0, 1'b1, tbl_word, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int k = 0; k < FRAME; k++)
            vecs.push_back(mkVec(1'b0, 1'b0, 8'hC3, 1'b1, 1'b1, tbl_bits[FRAME-1-k], k == FRAME - 1));
        vecs.push_back(mkVec(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < vecs.size(); i++) runVector("table", vecs[i]);

        // Back-to-back words with load_valid held, third word backpressured
        cap_bits.delete();
        words = '{8'hA5, 8'h5A, 8'hFF};
        idx = 0;
        for (int c = 0; c < 80 && (idx < 3 || m_rem > 0 || m_held); c++) begin
            runModelCycle("b2b", 1'b0, idx < 3, (idx < 3) ? words[idx] : 8'h00, acc);
            if (acc) idx++;
        end
        checkInt("b2b.accepted", idx, 3);
        checkStream("b2b", words);
        checkInt("b2b.contiguous", cap_last - cap_first + 1, cap_bits.size());

        // Reset after the third bit abandons the word; next word streams cleanly
        runModelCycle("rstmid", 1'b0, 1'b1, 8'hA5, acc);
        idleCycles("rstmid", 3);
        runModelCycle("rstmid", 1'b1, 1'b1, 8'h77, acc);
        cap_bits.delete();
        runModelCycle("rstmid", 1'b0, 1'b1, 8'h0F, acc);
        checkOne("rstmid.accept_after_reset", acc, 1'b1);
        idleCycles("rstmid", FRAME + 2);
        words = '{8'h0F};
        checkStream("rstmid", words);

`ifdef BIT_SERIALIZER_PARITY_EN
        cap_bits.delete();
        runModelCycle("parity", 1'b0, 1'b1, 8'h07, acc);
        idleCycles("parity", FRAME + 1);
        runModelCycle("parity", 1'b0, 1'b1, 8'h03, acc);
        idleCycles("parity", FRAME + 1);
        words = '{8'h07, 8'h03};
        checkStream("parity", words);
        checkOne("parity.bit9_of_03", cap_bits[2*FRAME-1], 1'b0);
`endif

        // Serial stream feeding an overlapping 101 detector
        cap_bits.delete();
        runModelCycle("det", 1'b0, 1'b1, 8'b1010_1101, acc);
        idleCycles("det", FRAME + 1);
        mask = 0;
        for (int i = 2; i < W && i < cap_bits.size(); i++)
            if (cap_bits[i-2] && !cap_bits[i-1] && cap_bits[i]) mask |= (1 << i);
        checkInt("det.pulse_mask", mask, 32'h94);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 600; c++)
            runModelCycle("rand", $urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
                          W'($urandom), acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
